// File: rtl/branch_seq_pkg.sv
// Shared definitions for the branch sequencer: state encoding,
// condition codes driven to the condition flip-flop, and IR field positions.
package branch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_STROBE  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RESOLVE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

    localparam int unsigned C2_HI  = 20;
    localparam int unsigned C2_LO  = 19;
    localparam int unsigned OFF_HI = 18;

endpackage

// File: rtl/branch_seq.sv
// Branch sequencer and PC owner: walks the condition flip-flop through
// select / strobe / settle / resolve, applies the sign-extended offset when
// CON is set, and handles the ordinary fetch increment while idle.
module branch_seq
    import branch_seq_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     OFF_W    = OFF_HI + 1,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             fetch_inc,
    input  logic             br_start,
    input  logic [31:0]      br_ir,
    input  logic             con_in,
    output logic [1:0]       cond_sel,
    output logic             con_strobe,
    output logic             reg_out_req,
    output logic [PC_W-1:0]  pc,
    output logic             br_busy,
    output logic             br_done,
    output logic             br_taken,
    output logic [CNT_W-1:0] taken_count
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   taken_count_q, taken_count_d;
    logic [1:0]         c2_q, c2_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [1:0]         cond_sel_q, cond_sel_d;
    logic               con_strobe_q, con_strobe_d;
    logic               reg_out_req_q, reg_out_req_d;
    logic               br_busy_q, br_busy_d;
    logic               br_done_q, br_done_d;
    logic               br_taken_q, br_taken_d;
    logic               taken_now;
    logic               in_seq;
    logic [PC_W-1:0]    off_ext;
    logic               unused_ir;

    assign unused_ir = ^br_ir[31:C2_HI+1];
    assign off_ext   = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};

    // Next-state, PC/counter update, and output decode from the next state
    // so that every output is a flop aligned with the state it belongs to.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        taken_count_d = taken_count_q;
        c2_d          = c2_q;
        off_d         = off_q;
        taken_now     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (br_start) begin
                    c2_d    = br_ir[C2_HI:C2_LO];
                    off_d   = br_ir[OFF_W-1:0];
                    state_d = ST_REQ;
                end else if (fetch_inc) begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            ST_REQ:    state_d = ST_STROBE;
            ST_STROBE: state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_RESOLVE;
            ST_RESOLVE: begin
                state_d   = ST_DONE;
                taken_now = con_in;
                if (con_in) begin
                    pc_d = pc_q + off_ext;
                    if (taken_count_q != '1) begin
                        taken_count_d = taken_count_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        in_seq        = state_d inside {ST_REQ, ST_STROBE, ST_SETTLE, ST_RESOLVE};
        cond_sel_d    = in_seq ? c2_d : COND_ZR;
        con_strobe_d  = (state_d == ST_STROBE);
        reg_out_req_d = in_seq;
        br_busy_d     = in_seq;
        br_done_d     = (state_d == ST_DONE);
        br_taken_d    = taken_now;
    end

    // State, PC, counter and registered outputs with asynchronous clear.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            taken_count_q <= '0;
            c2_q          <= COND_ZR;
            off_q         <= '0;
            cond_sel_q    <= COND_ZR;
            con_strobe_q  <= 1'b0;
            reg_out_req_q <= 1'b0;
            br_busy_q     <= 1'b0;
            br_done_q     <= 1'b0;
            br_taken_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            taken_count_q <= taken_count_d;
            c2_q          <= c2_d;
            off_q         <= off_d;
            cond_sel_q    <= cond_sel_d;
            con_strobe_q  <= con_strobe_d;
            reg_out_req_q <= reg_out_req_d;
            br_busy_q     <= br_busy_d;
            br_done_q     <= br_done_d;
            br_taken_q    <= br_taken_d;
        end
    end

    assign cond_sel    = cond_sel_q;
    assign con_strobe  = con_strobe_q;
    assign reg_out_req = reg_out_req_q;
    assign pc          = pc_q;
    assign br_busy     = br_busy_q;
    assign br_done     = br_done_q;
    assign br_taken    = br_taken_q;
    assign taken_count = taken_count_q;

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: reset, fetch increment, taken / not-taken
// branches, wrap, ignored and priority requests, async reset, saturation.
module tb_branch_seq;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        fetch_inc;
    logic        br_start;
    logic [31:0] br_ir;
    logic        con_in;
    logic [1:0]  cond_sel;
    logic        con_strobe;
    logic        reg_out_req;
    logic [31:0] pc;
    logic        br_busy;
    logic        br_done;
    logic        br_taken;
    logic [1:0]  taken_count;

    int checks   = 0;
    int failures = 0;

    branch_seq #(
        .PC_W     (32),
        .OFF_W    (19),
        .RESET_PC (32'h0),
        .CNT_W    (2)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .fetch_inc   (fetch_inc),
        .br_start    (br_start),
        .br_ir       (br_ir),
        .con_in      (con_in),
        .cond_sel    (cond_sel),
        .con_strobe  (con_strobe),
        .reg_out_req (reg_out_req),
        .pc          (pc),
        .br_busy     (br_busy),
        .br_done     (br_done),
        .br_taken    (br_taken),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [1:0] c2, input logic [18:0] off);
        return {11'b0, c2, off};
    endfunction

    // One complete branch; con_in is held at the opposite value outside RESOLVE.
    task automatic branch(input string tag, input logic [31:0] ir, input logic con,
                          input logic with_fetch, input logic poke,
                          input logic [31:0] exp_pc, input logic [1:0] exp_cnt);
        logic [1:0] c2;
        logic       in_seq;
        c2        = ir[20:19];
        con_in    = ~con;
        br_ir     = ir;
        br_start  = 1'b1;
        fetch_inc = with_fetch;
        tick;
        br_start  = 1'b0;
        fetch_inc = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            in_seq = (c <= 4);
            chk({tag, "/cond_sel"},    32'(cond_sel),    in_seq ? 32'(c2) : 32'd0);
            chk({tag, "/con_strobe"},  32'(con_strobe),  32'(c == 2));
            chk({tag, "/reg_out_req"}, 32'(reg_out_req), 32'(in_seq));
            chk({tag, "/br_busy"},     32'(br_busy),     32'(in_seq));
            chk({tag, "/br_done"},     32'(br_done),     32'(c == 5));
            chk({tag, "/br_taken"},    32'(br_taken),    (c == 5) ? 32'(con) : 32'd0);
            if (c == 5) begin
                chk({tag, "/pc"},          pc,                exp_pc);
                chk({tag, "/taken_count"}, 32'(taken_count),  32'(exp_cnt));
            end
            if (c == 3 && poke) begin
                br_start  = 1'b1;
                fetch_inc = 1'b1;
            end
            if (c == 4) begin
                br_start  = 1'b0;
                fetch_inc = 1'b0;
                con_in    = con;
            end else begin
                con_in = ~con;
            end
            if (c < 5) tick;
        end
        tick;
        chk({tag, "/post_done"},  32'(br_done),  32'd0);
        chk({tag, "/post_taken"}, 32'(br_taken), 32'd0);
        chk({tag, "/post_busy"},  32'(br_busy),  32'd0);
        chk({tag, "/post_pc"},    pc,            exp_pc);
        con_in = 1'b0;
    endtask

    initial begin
        clr_n     = 1'b1;
        fetch_inc = 1'b0;
        br_start  = 1'b0;
        br_ir     = '0;
        con_in    = 1'b0;
        #1 clr_n  = 1'b0;
        tick;
        tick;

        // Reset state
        chk("rst/pc",          pc,                32'h0);
        chk("rst/cond_sel",    32'(cond_sel),     32'd0);
        chk("rst/con_strobe",  32'(con_strobe),   32'd0);
        chk("rst/reg_out_req", 32'(reg_out_req),  32'd0);
        chk("rst/br_busy",     32'(br_busy),      32'd0);
        chk("rst/br_done",     32'(br_done),      32'd0);
        chk("rst/br_taken",    32'(br_taken),     32'd0);
        chk("rst/taken_count", 32'(taken_count),  32'd0);

        // Fetch increment x3, then up to 0x10
        clr_n     = 1'b1;
        fetch_inc = 1'b1;
        tick; tick; tick;
        fetch_inc = 1'b0;
        chk("fetch3/pc", pc, 32'h3);
        fetch_inc = 1'b1;
        for (int i = 0; i < 13; i++) tick;
        fetch_inc = 1'b0;
        chk("fetch16/pc", pc, 32'h10);

        // Taken, not-taken, negative offsets, wrap, saturation at 3
        branch("taken_p8",   mk_ir(2'b00, 19'd8),       1'b1, 1'b0, 1'b0, 32'h18,       2'd1);
        branch("taken_m8",   mk_ir(2'b11, 19'h7FFF8),   1'b1, 1'b0, 1'b0, 32'h10,       2'd2);
        branch("ntaken_m4",  mk_ir(2'b01, 19'h7FFFC),   1'b0, 1'b0, 1'b0, 32'h10,       2'd2);
        branch("taken_m4",   mk_ir(2'b10, 19'h7FFFC),   1'b1, 1'b0, 1'b0, 32'h0C,       2'd3);
        branch("to_top",     mk_ir(2'b01, 19'h7FFF2),   1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 2'd3);
        branch("wrap_p4",    mk_ir(2'b11, 19'd4),       1'b1, 1'b0, 1'b0, 32'h00000002, 2'd3);

        // Requests during SETTLE are ignored; fetch_inc with br_start is dropped
        branch("ignore_req", mk_ir(2'b01, 19'd0),       1'b0, 1'b0, 1'b1, 32'h2,        2'd3);
        branch("prio_start", mk_ir(2'b10, 19'd1),       1'b1, 1'b1, 1'b0, 32'h3,        2'd3);

        // Asynchronous reset in SETTLE
        br_ir    = mk_ir(2'b11, 19'd8);
        br_start = 1'b1;
        tick;
        br_start = 1'b0;
        tick;
        tick;
        chk("arst/in_settle_req", 32'(reg_out_req), 32'd1);
        #2 clr_n = 1'b0;
        #1;
        chk("arst/reg_out_req", 32'(reg_out_req), 32'd0);
        chk("arst/pc",          pc,               32'h0);
        chk("arst/br_busy",     32'(br_busy),     32'd0);
        chk("arst/cond_sel",    32'(cond_sel),    32'd0);
        chk("arst/taken_count", 32'(taken_count), 32'd0);
        con_in = 1'b1;
        tick;
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("arst/no_done", 32'(br_done), 32'd0);
        end
        con_in    = 1'b0;
        fetch_inc = 1'b1;
        tick;
        fetch_inc = 1'b0;
        chk("arst/fetch_pc", pc, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
